pipe_stall_ctrl: RTL and testbench

//  Hazard/stall scheduler for the 5-stage MIPS pipeline front end.
//  - Decides each cycle whether the IF stage may advance the PC and whether IF/ID holds.
//  - Bubbles ID/EX on stall.
//  - Owns the mult/div busy sequencer.
//  - Uses Tuse/Tnew comparison; forwarding covers every non-stalled case.

---
 rtl/pipe_stall_ctrl_pkg.sv | 33 +++
 rtl/md_busy_seq.sv | 57 +++++
 rtl/pipe_stall_ctrl.sv | 68 ++++++
 tb/tb_pipe_stall_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds MD sequencer states, cycle defaults and the operand hazard check.
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // A source operand must wait when a younger producer's result
  // arrives later than D needs it; r0 never carries a dependency.
  function automatic logic rd_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_waddr,
    input logic [1:0] e_tnew,
    input logic [4:0] m_waddr,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (addr == e_waddr) && (e_tnew > tuse);
    m_hit = (addr == m_waddr) && (m_tnew > tuse);
    return (addr != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/md_busy_seq.sv
// HI/LO unit busy sequencer: counts down a fixed latency per mult/div.
// Ports: clk, reset (async high), md_start, md_is_div in; md_busy out.
module md_busy_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  md_state_t        state;
  md_state_t        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A start while BUSY cannot occur (D is stalled); it is ignored.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (md_start) begin
          state_nx = BUSY;
          cnt_nx   = md_is_div ? CNT_W'(DIV_CYC)
                               : CNT_W'(MULT_CYC);
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  assign md_busy = (state == BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Front-end hazard/stall scheduler using Tuse/Tnew, plus stall counter.
// Ports: D/E/M register info and MD controls in; PC_en/d_en/e_clr/md_busy/stall_cnt out.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [1:0]  rs_tuse,
  input  logic [1:0]  rt_tuse,
  input  logic [4:0]  e_waddr,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_waddr,
  input  logic [1:0]  m_tnew,
  input  logic        d_is_md,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        PC_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  md_busy_seq #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .md_busy   (md_busy)
  );

  assign stall_rs = rd_hazard(rs_addr, rs_tuse, e_waddr, e_tnew,
                              m_waddr, m_tnew);
  assign stall_rt = rd_hazard(rt_addr, rt_tuse, e_waddr, e_tnew,
                              m_waddr, m_tnew);

  // A start in E this cycle already owns HI/LO for the D instr.
  assign stall_md = d_is_md && (md_busy || md_start);

  assign stall = stall_rs | stall_rt | stall_md;
  assign PC_en = ~stall;
  assign d_en  = ~stall;
  assign e_clr = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed cases plus random
// traffic against a countdown/arithmetic reference model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [1:0]  rs_tuse;
  logic [1:0]  rt_tuse;
  logic [4:0]  e_waddr;
  logic [1:0]  e_tnew;
  logic [4:0]  m_waddr;
  logic [1:0]  m_tnew;
  logic        d_is_md;
  logic        md_start;
  logic        md_is_div;
  logic        PC_en;
  logic        d_en;
  logic        e_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_left;
  longint      scnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_tuse   (rs_tuse),
    .rt_tuse   (rt_tuse),
    .e_waddr   (e_waddr),
    .e_tnew    (e_tnew),
    .m_waddr   (m_waddr),
    .m_tnew    (m_tnew),
    .d_is_md   (d_is_md),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .PC_en     (PC_en),
    .d_en      (d_en),
    .e_clr     (e_clr),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_hz(input logic [4:0] a,
                                input logic [1:0] tu);
    logic [4:0] dst [2];
    int         tn  [2];
    dst[0] = e_waddr;
    dst[1] = m_waddr;
    tn[0]  = int'(e_tnew);
    tn[1]  = int'(m_tnew);
    if (a == 5'd0 || tu == 2'd3) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (dst[i] == a && tn[i] > int'(tu)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ref_stall();
    bit md;
    md = d_is_md && (busy_left > 0 || md_start);
    return ref_hz(rs_addr, rs_tuse) || ref_hz(rt_addr, rt_tuse) || md;
  endfunction

  task automatic check_outs();
    bit s;
    s = ref_stall();
    chk("pc_en", {31'd0, PC_en}, {31'd0, ~s});
    chk("d_en", {31'd0, d_en}, {31'd0, ~s});
    chk("e_clr", {31'd0, e_clr}, {31'd0, s});
    chk("md_busy", {31'd0, md_busy}, {31'd0, busy_left > 0});
    chk("stall_cnt", stall_cnt, 32'(scnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (ref_stall() && scnt < 64'hFFFF_FFFF) scnt++;
      if (busy_left > 0) busy_left--;
      else if (md_start) busy_left = md_is_div ? 10 : 5;
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1 check_outs();
    tick();
  endtask

  task automatic idle_in();
    rs_addr   = 5'd0;
    rt_addr   = 5'd0;
    rs_tuse   = 2'd3;
    rt_tuse   = 2'd3;
    e_waddr   = 5'd0;
    e_tnew    = 2'd0;
    m_waddr   = 5'd0;
    m_tnew    = 2'd0;
    d_is_md   = 1'b0;
    md_start  = 1'b0;
    md_is_div = 1'b0;
  endtask

  initial begin
    int stalls;
    int busys;
    reset = 1'b1;
    idle_in();
    busy_left = 0;
    scnt = 0;
    @(negedge clk);
    #1;
    chk("rst_pc_en", {31'd0, PC_en}, 32'd1);
    chk("rst_d_en", {31'd0, d_en}, 32'd1);
    chk("rst_e_clr", {31'd0, e_clr}, 32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // load-use: lw r1 in E, add uses r1 next
    e_waddr = 5'd1; e_tnew = 2'd2;
    rs_addr = 5'd1; rs_tuse = 2'd1;
    #1 chk("lw_use_stall", {31'd0, e_clr}, 32'd1);
    #0 step();
    idle_in();
    #1 chk("lw_use_cnt", stall_cnt, 32'd1);
    #0 step();

    // forwardable result and r0 never stall
    e_waddr = 5'd1; e_tnew = 2'd1;
    rs_addr = 5'd1; rs_tuse = 2'd1;
    #1 chk("fwd_nostall", {31'd0, PC_en}, 32'd1);
    #0 step();
    e_waddr = 5'd0; e_tnew = 2'd2;
    rs_addr = 5'd0; rs_tuse = 2'd0;
    #1 chk("r0_nostall", {31'd0, PC_en}, 32'd1);
    #0 step();
    idle_in();
    m_waddr = 5'd4; m_tnew = 2'd1;
    rt_addr = 5'd4; rt_tuse = 2'd0;
    #1 chk("m_rt_stall", {31'd0, d_en}, 32'd0);
    #0 step();
    idle_in();

    // mult then HI/LO user held in D
    md_start = 1'b1; md_is_div = 1'b0; d_is_md = 1'b1;
    stalls = 0; busys = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!PC_en) stalls++;
      if (md_busy) busys++;
      step();
      md_start = 1'b0;
    end
    chk("mult_stalls", 32'(stalls), 32'd6);
    chk("mult_busy", 32'(busys), 32'd5);
    idle_in();

    // div with an unrelated D instr
    md_start = 1'b1; md_is_div = 1'b1;
    rs_addr = 5'd7; rs_tuse = 2'd0;
    e_waddr = 5'd3; e_tnew = 2'd2;
    stalls = 0; busys = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (!PC_en) stalls++;
      if (md_busy) busys++;
      step();
      md_start = 1'b0;
    end
    chk("div_busy", 32'(busys), 32'd10);
    chk("div_nostall", 32'(stalls), 32'd0);
    idle_in();

    // reset in the middle of a div
    md_start = 1'b1; md_is_div = 1'b1;
    step();
    md_start = 1'b0;
    step();
    step();
    #1 chk("div_busy3", {31'd0, md_busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_busy_drop", {31'd0, md_busy}, 32'd0);
    chk("rst_cnt_clr", stall_cnt, 32'd0);
    busy_left = 0;
    scnt = 0;
    @(negedge clk);
    reset = 1'b0;
    d_is_md = 1'b1;
    #1 chk("post_rst_md", {31'd0, PC_en}, 32'd1);
    #0 step();
    idle_in();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rs_addr   = 5'($urandom_range(0, 3));
      rt_addr   = 5'($urandom_range(0, 3));
      rs_tuse   = 2'($urandom_range(0, 3));
      rt_tuse   = 2'($urandom_range(0, 3));
      e_waddr   = 5'($urandom_range(0, 3));
      e_tnew    = 2'($urandom_range(0, 3));
      m_waddr   = 5'($urandom_range(0, 3));
      m_tnew    = 2'($urandom_range(0, 3));
      d_is_md   = ($urandom_range(0, 3) == 0);
      md_is_div = 1'($urandom_range(0, 1));
      md_start  = (busy_left == 0) && ($urandom_range(0, 4) == 0);
      step();
    end
    idle_in();
    step();

    // saturation: preload near the top, then stall past it
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt;
    scnt = 64'hFFFF_FFFD;
    e_waddr = 5'd1; e_tnew = 2'd2;
    rs_addr = 5'd1; rs_tuse = 2'd1;
    for (int i = 0; i < 5; i++) step();
    idle_in();
    #1 chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
